// File: rtl/frac_lutk_dbuf_tile.sv
`default_nettype none
// ============================================================================
// Module   : frac_lutk_dbuf_tile
// Purpose  : Fracturable K-input LUT with a double-buffered configuration
//            chain. A serial bitstream is shifted into a shadow chain while the
//            live (active) configuration keeps driving the LUT. A single-cycle
//            commit copies the shadow into the active copy once exactly N
//            fresh bits have been shifted in.
// Ports    : prog_clk     - configuration clock (rising edge)
//            pReset       - asynchronous active-high reset
//            ccff_en      - shift enable for the chain
//            ccff_head    - serial configuration input
//            ccff_tail    - serial configuration output (daisy chain)
//            cfg_commit   - request to copy shadow -> active
//            frac_lut_in  - LUT inputs, bit 0 is the index LSB
//            lut_km1_out  - two fractured (K-1)-LUT outputs
//            lut_k_out    - full K-LUT output
//            cfg_loaded   - shadow holds exactly N fresh bits
//            cfg_active   - a configuration has been committed since reset
//            cfg_err      - sticky commit / overflow error
// Revision : 1.0 - initial release
// ============================================================================
module frac_lutk_dbuf_tile #(
    parameter int K = 4     // LUT input count, legal range 2..6
) (
    input  logic         prog_clk,
    input  logic         pReset,
    input  logic         ccff_en,
    input  logic         ccff_head,
    output logic         ccff_tail,
    input  logic         cfg_commit,
    input  logic [K-1:0] frac_lut_in,
    output logic [1:0]   lut_km1_out,
    output logic         lut_k_out,
    output logic         cfg_loaded,
    output logic         cfg_active,
    output logic         cfg_err
);

    // Chain length: 2^K truth-table bits plus one mode bit.
    localparam int N  = (1 << K) + 1;
    localparam int S  = 1 << K;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] C_N_CNT = CW'(N);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic [N-1:0]  r_shadow;
    logic [N-1:0]  r_active;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_cfg_active;
    logic          r_cfg_err;

    logic          w_full;
    logic          w_loaded;
    logic          w_commit_ok;
    logic          w_commit_fail;
    logic [S-1:0]  w_sram;
    logic          w_mode;
    logic [K-2:0]  w_lo_idx;

    // ------------------------------------------------------------------
    // Commit qualification. A commit while shifting is always rejected so
    // a half-moved chain can never reach the active copy.
    // ------------------------------------------------------------------
    assign w_full        = (r_cnt == C_N_CNT);
    assign w_loaded      = w_full && !r_ovf;
    assign w_commit_ok   = cfg_commit && w_loaded && !ccff_en;
    assign w_commit_fail = cfg_commit && !w_commit_ok;

    // ------------------------------------------------------------------
    // Shadow shift chain: bit 0 takes the head, the oldest bit sits at
    // N-1 and is presented on the tail. The shadow survives a commit so a
    // downstream tile still sees the previous bitstream replayed.
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_shadow <= '0;
        end else if (ccff_en) begin
            r_shadow <= {r_shadow[N-2:0], ccff_head};
        end
    end

    assign ccff_tail = r_shadow[N-1];

    // ------------------------------------------------------------------
    // Shift accounting. The counter saturates at N; any shift beyond that
    // marks the shadow as overflowed until a successful commit or reset.
    // A rejected commit leaves the accounting to the shift alone.
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_commit_ok) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (ccff_en) begin
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end

    assign cfg_loaded = w_loaded;

    // ------------------------------------------------------------------
    // Active configuration and status flags. Only a successful commit
    // touches the active copy; shifting never does.
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_active     <= '0;
            r_cfg_active <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else if (w_commit_ok) begin
            r_active     <= r_shadow;
            r_cfg_active <= 1'b1;
            r_cfg_err    <= 1'b0;
        end else if (w_commit_fail) begin
            r_cfg_err    <= 1'b1;
        end
    end

    assign cfg_active = r_cfg_active;
    assign cfg_err    = r_cfg_err;

    // ------------------------------------------------------------------
    // LUT read-out. The first bit shifted in (which ends at N-1) is the
    // mode bit; truth-table bit j sits at position j.
    // In fractured mode the top input is dropped and the two halves of the
    // table act as independent (K-1)-input LUTs.
    // ------------------------------------------------------------------
    assign w_sram   = r_active[S-1:0];
    assign w_mode   = r_active[N-1];
    assign w_lo_idx = frac_lut_in[K-2:0];

    assign lut_k_out      = w_sram[frac_lut_in];
    assign lut_km1_out[0] = w_mode & w_sram[{1'b0, w_lo_idx}];
    assign lut_km1_out[1] = w_mode & w_sram[{1'b1, w_lo_idx}];

endmodule
`default_nettype wire

// File: doc/frac_lutk_dbuf_tile.md
# frac_lutk_dbuf_tile

Parametrised fracturable K-input LUT tile with a double-buffered configuration chain. It generalises the fixed 4-input fractured LUT primitive and its chain memory. The block sits in the CLB physical-mode hierarchy on the prog_clk/pReset configuration domain. It adds the following over that primitive:
- Width parameter K.
- Shift-enable on the chain.
- Shifted-bit accounting.
- A commit handshake, so the live LUT keeps its old function while a new bitstream is shifted through.

## Interface
Parameters:
- K, default 4, LUT input count; legal range 2..6.
- N, derived and not overridable: N = 2^K + 1, the chain length (2^K truth-table bits plus 1 mode bit).

Ports:
- prog_clk  input  1  sole clock; all state updates on its rising edge.
- pReset  input  1  reset; asynchronous, active-high.
- ccff_en  input  1  chain shift enable.
- ccff_head  input  1  serial configuration data in.
- ccff_tail  output  1  serial configuration data out, for daisy-chaining.
- cfg_commit  input  1  single-cycle request to copy the shadow chain into the active configuration.
- frac_lut_in  input  K  LUT inputs; bit 0 is the index LSB.
- lut_km1_out  output  2  fractured (K-1)-LUT outputs.
- lut_k_out  output  1  full K-LUT output.
- cfg_loaded  output  1  shadow chain holds exactly N fresh bits.
- cfg_active  output  1  a valid configuration has been committed since reset.
- cfg_err  output  1  sticky commit/overflow error.

## Operation
- Registers:
  - shadow[0:N-1]: the shift chain.
  - active[0:N-1]: drives the LUT, mapped as {sram[0:2^K-1], mode}.
  - cnt: width clog2(N+1).
  - ovf, cfg_active_r, cfg_err_r.
- Shift, when ccff_en=1:
  - shadow[0] <= ccff_head; shadow[i] <= shadow[i-1].
  - ccff_tail = shadow[N-1]. The first bit shifted in after N shifts becomes the mode bit.
- Shifting never touches the active registers.
- Counter:
  - cnt increments on each shift and saturates at N.
  - A shift while cnt==N sets ovf.
  - cfg_loaded = (cnt==N) && !ovf.
- Commit, on cfg_commit=1:
  - Success requires cfg_loaded=1 and ccff_en=0. On success: active <= shadow, cfg_active <= 1, cfg_err <= 0, cnt <= 0, ovf <= 0. The shadow is retained.
  - Any other condition is a failure: cfg_err <= 1, active unchanged, cnt/ovf unchanged.
  - If ccff_en=1 in the same cycle as a failed commit, the shift still occurs.
- cfg_err is sticky until the next successful commit or pReset.
- LUT function (combinational from active and frac_lut_in):
  - idx = frac_lut_in as unsigned; lut_k_out = sram[idx].
  - mode=1 (fractured): lut_km1_out[0] = sram[frac_lut_in[0:K-2]]; lut_km1_out[1] = sram[2^(K-1) + frac_lut_in[0:K-2]]. frac_lut_in[K-1] is ignored for these outputs.
  - mode=0: lut_km1_out = 2'b00.
- Reset: shadow, active, cnt, ovf, cfg_active, cfg_err all 0. Outputs during and after reset: ccff_tail=0, lut_k_out=0, lut_km1_out=0, cfg_loaded=0, cfg_active=0, cfg_err=0.
- pReset during a shift sequence discards the partial bitstream; the count restarts from 0.

## Timing
- One bit per prog_clk cycle with ccff_en=1. ccff_en=0 holds the chain and counter.
- Bit presented on ccff_head appears on ccff_tail after exactly N enabled edges.
- cfg_loaded rises combinationally after the Nth enabled edge.
- New LUT function is visible on the outputs immediately after the commit edge; latency is 1 cycle from the cfg_commit sample.
- cfg_err/cfg_active update on the commit edge.
- Back-to-back commit: the second commit fails (cnt=0) and sets cfg_err. The active configuration is unchanged.
- LUT outputs are purely combinational from frac_lut_in once committed; no clock dependence.

## Test plan
- Reset: assert pReset mid-shift (cnt=9, K=4) -> all outputs 0 asynchronously; after release cnt=0 and cfg_loaded=0.
- Load and commit AND4 (K=4, N=17):
  - Shift mode=0 first, then sram[15]..sram[0] = 1,0,...,0; pulse cfg_commit -> next cycle cfg_active=1.
  - lut_k_out=1 only for frac_lut_in=4'hF; lut_km1_out=00.
- Fractured mode: commit sram=16'hA5C3 with mode=1 -> for every input, lut_km1_out[0]=sram[in[2:0]], lut_km1_out[1]=sram[8+in[2:0]], lut_k_out=sram[in].
- Double-buffer: with the AND4 config live, shift a new 17-bit config -> LUT outputs stay AND4 throughout and switch only after commit. ccff_tail replays the old shadow bits in order.
- Error cases:
  - Commit at cnt=16 -> cfg_err=1, function unchanged.
  - 18 shifts then commit -> cfg_err=1.
  - Commit with ccff_en=1 -> cfg_err=1.
  - A subsequent valid 17-bit load plus commit -> cfg_err=0.
- Parameter sweep: K=2 (N=5) and K=6 (N=65), random configs, with an exhaustive input check against a reference model.
